// File: rtl/mips_defs.sv
// Shared MEM-stage definitions: store width codes, buffer sizing, entry payload.
package mips_defs;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned WORD_W   = ADDR_W - 2;
  localparam int unsigned SB_DEPTH = 4;

  localparam logic [TYPE_W-1:0] STORE_WORD = 3'd0;
  localparam logic [TYPE_W-1:0] STORE_HALF = 3'd1;
  localparam logic [TYPE_W-1:0] STORE_BYTE = 3'd2;

  // One queued store, kept exactly as presented by the MEM stage.
  typedef struct packed {
    logic [TYPE_W-1:0] st_type;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Word address used for load/store overlap detection.
  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_match.sv
// Compares a load word address against every occupied store-buffer entry.
module sb_match
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                         ld_valid,
  input  logic [WORD_W-1:0]            ld_word,
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][WORD_W-1:0] ent_word,
  output logic                         hazard
);

  logic [DEPTH-1:0] hit;

  // Per-entry word compare, qualified by occupancy.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = ent_valid[i] && (ent_word[i] == ld_word);
    end
  end

  assign hazard = ld_valid && (|hit);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: queues stores and drains
// them whenever the memory port is not needed by a load, forcing drains when
// a load overlaps a queued store.
module store_buffer
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              St_Valid,
  input  logic [TYPE_W-1:0] St_Type,
  input  logic [ADDR_W-1:0] St_Addr,
  input  logic [DATA_W-1:0] St_Data,
  input  logic              Ld_Valid,
  input  logic [ADDR_W-1:0] Ld_Addr,
  output logic              Stall,
  output logic              MemWrite,
  output logic [TYPE_W-1:0] StoreType,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DataW,
  output logic [2:0]        Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sb_entry_t                    ent_q [DEPTH];
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [CNT_W-1:0]             count_q;

  logic [DEPTH-1:0][WORD_W-1:0] ent_word;
  sb_entry_t                    head_e;
  sb_entry_t                    new_e;
  logic                         hazard;
  logic                         full;
  logic                         drain;
  logic                         enq;

  // Word addresses of all entries for the overlap comparator.
  always_comb begin
    ent_word = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_word[i] = word_of(ent_q[i].addr);
    end
  end

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .ld_valid  (Ld_Valid),
    .ld_word   (word_of(Ld_Addr)),
    .ent_valid (valid_q),
    .ent_word  (ent_word),
    .hazard    (hazard)
  );

  // Control decisions; everything is held quiet while reset is asserted.
  always_comb begin
    full   = (count_q == CNT_W'(DEPTH));
    head_e = ent_q[head_q];
    new_e  = '{st_type: St_Type, addr: St_Addr, data: St_Data};
    Stall  = reset && (hazard || (St_Valid && full));
    drain  = reset && (count_q != '0) && (!Ld_Valid || hazard);
    // A store presented alongside a load is dropped: the cycle is a load.
    enq    = reset && St_Valid && !Ld_Valid && !Stall;
  end

  // Memory port steering: drain write, load read, or idle pass-through.
  always_comb begin
    MemWrite  = 1'b0;
    Addr      = St_Addr;
    StoreType = STORE_WORD;
    DataW     = '0;
    if (drain) begin
      MemWrite  = 1'b1;
      Addr      = head_e.addr;
      StoreType = head_e.st_type;
      DataW     = head_e.data;
    end else if (reset && Ld_Valid) begin
      Addr      = Ld_Addr;
    end
  end

  // Pointer, occupancy and valid-bit bookkeeping with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Entry payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[tail_q] <= new_e;
    end
  end

  assign Count = 3'(count_q);

endmodule

// File: tb/tb_store_buffer.sv
// Randomised and directed checks of store_buffer against a queue-based model.
module tb_store_buffer;
  import mips_defs::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        St_Valid;
  logic [2:0]  St_Type;
  logic [31:0] St_Addr;
  logic [31:0] St_Data;
  logic        Ld_Valid;
  logic [31:0] Ld_Addr;
  logic        Stall;
  logic        MemWrite;
  logic [2:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] DataW;
  logic [2:0]  Count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .St_Valid  (St_Valid),
    .St_Type   (St_Type),
    .St_Addr   (St_Addr),
    .St_Data   (St_Data),
    .Ld_Valid  (Ld_Valid),
    .Ld_Addr   (Ld_Addr),
    .Stall     (Stall),
    .MemWrite  (MemWrite),
    .StoreType (StoreType),
    .Addr      (Addr),
    .DataW     (DataW),
    .Count     (Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] dut_log[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        o_stall, o_mw;
  logic [2:0]  o_type, o_count;
  logic [31:0] o_addr, o_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model.
  task automatic step(input logic rst, input logic sv, input logic [2:0] st,
                      input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la);
    logic hz, dr, e_stall;
    int   occ;
    @(negedge clk);
    reset = rst; St_Valid = sv; St_Type = st; St_Addr = sa; St_Data = sd;
    Ld_Valid = lv; Ld_Addr = la;
    #1;
    o_stall = Stall; o_mw = MemWrite; o_addr = Addr; o_data = DataW;
    o_type = StoreType; o_count = Count;
    if (MemWrite) dut_log.push_back(Addr);
    occ = model_q.size();
    hz = 1'b0;
    if (lv) foreach (model_q[i]) if (model_q[i].a[31:2] == la[31:2]) hz = 1'b1;
    check_eq("count", 32'(Count), 32'(occ));
    if (!rst) begin
      check_eq("rst_stall", 32'(Stall), 32'd0);
      check_eq("rst_memwrite", 32'(MemWrite), 32'd0);
      model_q.delete();
    end else begin
      e_stall = hz || (sv && occ == int'(DEPTH));
      dr = (occ > 0) && (!lv || hz);
      check_eq("stall", 32'(Stall), 32'(e_stall));
      check_eq("memwrite", 32'(MemWrite), 32'(dr));
      if (dr) begin
        check_eq("drain_addr", Addr, model_q[0].a);
        check_eq("drain_type", 32'(StoreType), 32'(model_q[0].t));
        check_eq("drain_data", DataW, model_q[0].d);
        void'(model_q.pop_front());
      end else if (lv) begin
        check_eq("load_addr", Addr, la);
      end else begin
        check_eq("idle_addr", Addr, sa);
        check_eq("idle_type", 32'(StoreType), 32'd0);
        check_eq("idle_data", DataW, 32'd0);
      end
      if (sv && !lv && !e_stall) model_q.push_back('{t: st, a: sa, d: sd});
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b0; St_Valid = 1'b0; St_Type = '0; St_Addr = '0; St_Data = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0;
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Single word store drains on the next free cycle.
    step(1'b1, 1'b1, STORE_WORD, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    idle();
    check_eq("sw_count_before", 32'(o_count), 32'd1);
    check_eq("sw_memwrite", 32'(o_mw), 32'd1);
    check_eq("sw_addr", o_addr, 32'h10);
    check_eq("sw_data", o_data, 32'hDEADBEEF);
    check_eq("sw_type", 32'(o_type), 32'd0);
    idle();
    check_eq("sw_count_after", 32'(o_count), 32'd0);

    // Back-to-back stores keep write order and never stall.
    dut_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, STORE_WORD, 32'(4 * i), 32'(100 + i), 1'b0, 32'd0);
      check_eq("b2b_stall", 32'(o_stall), 32'd0);
    end
    idle(); idle();
    check_eq("b2b_nwrites", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
      check_eq("b2b_order", dut_log[i], 32'(4 * i));

    // Stores interleaved with non-overlapping loads: occupancy stays bounded.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, STORE_WORD, 32'h100 + 32'(4 * i), 32'(i), 1'b0, 32'd0);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h1000);
      check_eq("ld_block_stall", 32'(o_stall), 32'd0);
      check_eq("ld_block_cnt_le", 32'(o_count <= 3'(DEPTH)), 32'd1);
    end
    idle(); idle();

    // Byte store overlapping a word load forces a drain under Stall.
    step(1'b1, 1'b1, STORE_BYTE, 32'h21, 32'hAB, 1'b0, 32'd0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h20);
    check_eq("haz_stall", 32'(o_stall), 32'd1);
    check_eq("haz_type", 32'(o_type), 32'd2);
    check_eq("haz_addr", o_addr, 32'h21);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h20);
    check_eq("haz_clear_stall", 32'(o_stall), 32'd0);
    check_eq("haz_clear_addr", o_addr, 32'h20);

    // Non-overlapping load bypasses the queued store.
    step(1'b1, 1'b1, STORE_WORD, 32'h44, 32'h5555, 1'b0, 32'd0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h40);
    check_eq("byp_stall", 32'(o_stall), 32'd0);
    check_eq("byp_memwrite", 32'(o_mw), 32'd0);
    check_eq("byp_addr", o_addr, 32'h40);
    idle();
    check_eq("byp_drain_addr", o_addr, 32'h44);

    // Reset while a store is pending discards it.
    step(1'b1, 1'b1, STORE_HALF, 32'h80, 32'h1234, 1'b0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    idle();
    check_eq("rst_count", 32'(o_count), 32'd0);
    check_eq("rst_nowrite", 32'(o_mw), 32'd0);
    idle();
    check_eq("rst_nowrite2", 32'(o_mw), 32'd0);

    // Random traffic over a small address window to provoke overlaps.
    for (int n = 0; n < 1500; n++) begin
      logic        rst, sv, lv;
      logic [31:0] sa, la;
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      sv  = ($urandom_range(0, 1) == 1);
      lv  = ($urandom_range(0, 2) == 0);
      sa  = 32'($urandom_range(0, 63));
      la  = 32'($urandom_range(0, 63));
      step(rst, sv, 3'($urandom_range(0, 2)), sa, $urandom, lv, la);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
